// File: rtl/soc_ctrl_obi_regs.sv
// SoC control register file on OBI: BOOTADDR, FETCHEN, CORESTATUS with end-of-computation pulse.
// Define SOC_CTRL_ERR_RESP_EN to flag unmapped accesses and illegal FETCHEN writes with err_o.
module soc_ctrl_obi_regs #(
  parameter logic [31:0] BootAddrDefault = 32'h1000_0000,
  parameter int unsigned WindowBytes     = 4096,
  parameter int unsigned IdWidth         = 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               req_i,
  output logic               gnt_o,
  input  logic [31:0]        addr_i,
  input  logic               we_i,
  input  logic [3:0]         be_i,
  input  logic [31:0]        wdata_i,
  input  logic [IdWidth-1:0] aid_i,
  output logic               rvalid_o,
  output logic [31:0]        rdata_o,
  output logic               err_o,
  output logic [IdWidth-1:0] rid_o,
  output logic [31:0]        boot_addr_o,
  output logic               fetch_en_o,
  output logic [31:0]        core_status_o,
  output logic               eoc_o
);
  localparam int unsigned AW = $clog2(WindowBytes);

  typedef enum logic {IDLE, RESP} state_e;
  state_e state_q, state_d;

  logic [1:0]         sel;
  logic               mapped;
  logic [31:0]        bmask;
  logic               wr, wr_boot, wr_fetch, wr_status;
  logic [31:0]        boot_q, boot_d;
  logic               fetch_q, fetch_d;
  logic [31:0]        status_q, status_d;
  logic               eoc_q, eoc_set;
  logic [31:0]        rdata_q, rdata_d;
  logic               err_q, err_d;
  logic [IdWidth-1:0] rid_q;
  logic               unused_addr;

  // Only the window offset is decoded; the byte lane bits are don't-care.
  assign sel         = addr_i[3:2];
  assign mapped      = (addr_i[AW-1:4] == '0);
  assign unused_addr = ^{addr_i[31:AW], addr_i[1:0]};

  always_comb begin
    bmask = '0;
    for (int i = 0; i < 4; i++) bmask[8*i +: 8] = {8{be_i[i]}};
  end

  assign wr        = req_i & we_i & mapped;
  assign wr_boot   = wr & (sel == 2'd0);
  assign wr_fetch  = wr & (sel == 2'd1);
  assign wr_status = wr & (sel == 2'd2);

  assign boot_d   = (boot_q & ~bmask) | (wdata_i & bmask);
  assign fetch_d  = be_i[0] ? wdata_i[0] : fetch_q;
  assign status_d = (status_q & ~bmask) | (wdata_i & bmask);
  // Only a 0->1 transition of the done bit signals end of computation.
  assign eoc_set  = wr_status & ~status_q[31] & status_d[31];

  // Reads see pre-write contents because registers update at the same edge.
  always_comb begin
    rdata_d = '0;
    if (req_i && !we_i && mapped) begin
      case (sel)
        2'd0:    rdata_d = boot_q;
        2'd1:    rdata_d = {31'd0, fetch_q};
        2'd2:    rdata_d = status_q;
        default: rdata_d = '0;
      endcase
    end
  end

`ifdef SOC_CTRL_ERR_RESP_EN
  always_comb begin
    err_d = 1'b0;
    if (req_i) begin
      if (!mapped || sel == 2'd3) err_d = 1'b1;
      else if (we_i && sel == 2'd1 && |(wdata_i & bmask & 32'hFFFF_FFFE)) err_d = 1'b1;
    end
  end
`else
  assign err_d = 1'b0;
`endif

  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    if (req_i) state_d = RESP;
      RESP:    if (req_i) state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      rdata_q <= '0;
      err_q   <= 1'b0;
      rid_q   <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      rid_q   <= req_i ? aid_i : '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      boot_q   <= BootAddrDefault;
      fetch_q  <= 1'b0;
      status_q <= '0;
      eoc_q    <= 1'b0;
    end else begin
      if (wr_boot)   boot_q   <= boot_d;
      if (wr_fetch)  fetch_q  <= fetch_d;
      if (wr_status) status_q <= status_d;
      eoc_q <= eoc_set;
    end
  end

  assign gnt_o         = 1'b1;
  assign rvalid_o      = (state_q == RESP);
  assign rdata_o       = rdata_q;
  assign err_o         = err_q;
  assign rid_o         = rid_q;
  assign boot_addr_o   = boot_q;
  assign fetch_en_o    = fetch_q;
  assign core_status_o = status_q;
  assign eoc_o         = eoc_q;
endmodule

// File: tb/tb_soc_ctrl_obi_regs.sv
// Bench for soc_ctrl_obi_regs: directed test-plan sequence plus random traffic against a register-array model.
module tb_soc_ctrl_obi_regs;
  localparam int unsigned IdWidth = 1;
  localparam logic [31:0] BootDef = 32'h1000_0000;

  logic               clk = 1'b0;
  logic               rst_ni = 1'b0;
  logic               req_i = 1'b0, we_i = 1'b0;
  logic               gnt_o, rvalid_o, err_o, fetch_en_o, eoc_o;
  logic [31:0]        addr_i = '0, wdata_i = '0;
  logic [3:0]         be_i = '0;
  logic [IdWidth-1:0] aid_i = '0, rid_o;
  logic [31:0]        rdata_o, boot_addr_o, core_status_o;

  int n_cmp = 0, n_bad = 0;

  // Model: four word slots, each with the set of bits software can change.
  logic [31:0] m [4];
  logic [31:0] wmask [4];

  soc_ctrl_obi_regs #(.BootAddrDefault(BootDef), .WindowBytes(4096), .IdWidth(IdWidth)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .req_i(req_i), .gnt_o(gnt_o), .addr_i(addr_i),
    .we_i(we_i), .be_i(be_i), .wdata_i(wdata_i), .aid_i(aid_i), .rvalid_o(rvalid_o),
    .rdata_o(rdata_o), .err_o(err_o), .rid_o(rid_o), .boot_addr_o(boot_addr_o),
    .fetch_en_o(fetch_en_o), .core_status_o(core_status_o), .eoc_o(eoc_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m[0] = BootDef; m[1] = '0; m[2] = '0; m[3] = '0;
  endtask

  // One bus cycle: drive at negedge, check the response just after the next rising edge.
  task automatic cyc(input bit rq, input bit w, input logic [31:0] a, input logic [3:0] b,
                     input logic [31:0] d, input logic [IdWidth-1:0] id);
    int idx;
    bit mapped, err_e, eoc_e;
    logic [31:0] bm, old;
    idx    = int'(a[3:2]);
    mapped = (a[11:4] == 8'd0);
    bm     = {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
    old    = mapped ? m[idx] : 32'd0;
    err_e  = 1'b0;
`ifdef SOC_CTRL_ERR_RESP_EN
    if (rq && (!mapped || idx == 3 || (w && idx == 1 && ((d & bm & 32'hFFFF_FFFE) != 0)))) err_e = 1'b1;
`endif
    eoc_e = 1'b0;
    if (rq && w && mapped) begin
      m[idx] = (m[idx] & ~(bm & wmask[idx])) | (d & bm & wmask[idx]);
      eoc_e  = (idx == 2) && !old[31] && m[2][31];
    end
    @(negedge clk);
    req_i = rq; we_i = w; addr_i = a; be_i = b; wdata_i = d; aid_i = id;
    @(posedge clk);
    #1;
    chk("rvalid", 32'(rvalid_o), 32'(rq));
    chk("err", 32'(err_o), 32'(err_e));
    if (rq) chk("rid", 32'(rid_o), 32'(id));
    if (rq && !w) chk("rdata", rdata_o, old);
    chk("eoc", 32'(eoc_o), 32'(eoc_e));
    chk("boot_addr", boot_addr_o, m[0]);
    chk("fetch_en", 32'(fetch_en_o), 32'(m[1][0]));
    chk("core_status", core_status_o, m[2]);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 32'd0, 4'h0, 32'd0, '0);
  endtask

  initial begin
    logic [31:0] a;
    wmask[0] = 32'hFFFF_FFFF; wmask[1] = 32'h1; wmask[2] = 32'hFFFF_FFFF; wmask[3] = 32'h0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_boot", boot_addr_o, BootDef);
    chk("rst_fetch", 32'(fetch_en_o), 32'd0);
    chk("rst_status", core_status_o, 32'd0);
    chk("rst_eoc", 32'(eoc_o), 32'd0);
    chk("rst_rvalid", 32'(rvalid_o), 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_rid", 32'(rid_o), 32'd0);
    chk("gnt", 32'(gnt_o), 32'd1);
    @(negedge clk) rst_ni = 1'b1;

    // Back-to-back reads after reset
    cyc(1, 0, 32'h0, 4'hF, 0, 1'b1);
    chk("b2b_rd0", rdata_o, 32'h1000_0000);
    cyc(1, 0, 32'h4, 4'hF, 0, 1'b0);
    cyc(1, 0, 32'h8, 4'hF, 0, 1'b1);
    idle();
    // Byte-enabled boot address write
    cyc(1, 1, 32'h0, 4'b0101, 32'hDEAD_BEEF, 0);
    chk("boot_be", boot_addr_o, 32'h10AD_00EF);
    cyc(1, 0, 32'h0, 4'hF, 0, 0);
    // Fetch enable set then cleared by write with upper bits only
    cyc(1, 1, 32'h4, 4'hF, 32'h1, 0);
    chk("fetch_set", 32'(fetch_en_o), 32'd1);
    cyc(1, 1, 32'h4, 4'hF, 32'hFFFF_FFFE, 1);
    cyc(1, 0, 32'h4, 4'hF, 0, 0);
    chk("fetch_rd", rdata_o, 32'd0);
    // End of computation pulses
    cyc(1, 1, 32'h8, 4'hF, 32'h8000_0000, 0);
    chk("eoc_pulse", 32'(eoc_o), 32'd1);
    idle();
    cyc(1, 1, 32'h8, 4'hF, 32'h8000_0000, 0);
    cyc(1, 1, 32'h8, 4'hF, 32'h0, 0);
    cyc(1, 1, 32'h8, 4'hF, 32'h8000_0005, 1);
    chk("eoc_code", core_status_o, 32'h8000_0005);
    idle();
    // Read-then-write ordering, no-op write, unmapped and reserved offsets
    cyc(1, 0, 32'h8, 4'hF, 0, 0);
    cyc(1, 1, 32'h8, 4'hF, 32'h1234, 1);
    cyc(1, 0, 32'h8, 4'hF, 0, 0);
    chk("rw_new", rdata_o, 32'h1234);
    cyc(1, 1, 32'h0, 4'h0, 32'hFFFF_FFFF, 1);
    cyc(1, 0, 32'h40, 4'hF, 0, 1);
    chk("unmapped_rd", rdata_o, 32'd0);
    cyc(1, 1, 32'h40, 4'hF, 32'hFFFF_FFFF, 0);
    cyc(1, 1, 32'hC, 4'hF, 32'hFFFF_FFFF, 0);
    cyc(1, 0, 32'hC, 4'hF, 0, 1);
    idle();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 6))
        0, 1: a = 32'h0;
        2:    a = 32'h4;
        3, 4: a = 32'h8;
        5:    a = 32'hC;
        default: a = 32'($urandom_range(0, 4095));
      endcase
      if ($urandom_range(0, 3) == 0) a = {a[31:12] ^ 20'($urandom), a[11:2], 2'($urandom)};
      cyc($urandom_range(0, 4) != 0, $urandom_range(0, 1) == 1, a, 4'($urandom),
          ($urandom_range(0, 2) == 0) ? ($urandom & 32'h8000_00FF) : $urandom, IdWidth'($urandom));
    end

    // Reset while a response and an eoc pulse are pending
    idle();
    cyc(1, 1, 32'h8, 4'hF, 32'h0, 0);
    cyc(1, 1, 32'h8, 4'hF, 32'h8000_0001, 1);
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_rvalid", 32'(rvalid_o), 32'd0);
    chk("mid_rst_eoc", 32'(eoc_o), 32'd0);
    chk("mid_rst_boot", boot_addr_o, BootDef);
    chk("mid_rst_status", core_status_o, 32'd0);
    model_reset();
    @(negedge clk);
    req_i = 1'b0;
    rst_ni = 1'b1;
    cyc(1, 0, 32'h0, 4'hF, 0, 1);
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/soc_ctrl_obi_regs.md
# soc_ctrl_obi_regs

OBI subordinate implementing the SoC control register file: boot address, fetch enable and core status. It is the responder end of the accesses the testbench and the core issue to the SoC-control peripheral window: JTAG/OBI writes that set the boot address and release the core, and core writes to the status register that signal end of test. It sits on the peripheral demux and drives the boot and fetch-enable inputs of the core.

## Interface
- `BootAddrDefault`, `32'h1000_0000`: reset value of BOOTADDR.
- `WindowBytes`, `4096`: size of the decoded window; offsets at or above 0x10 inside the window are unmapped.
- `IdWidth`, `1`: OBI transaction ID width.

- `clk_i`  in  1  system clock
- `rst_ni`  in  1  reset, asynchronous, active-low
- `req_i`  in  1  OBI request
- `gnt_o`  out  1  OBI grant
- `addr_i`  in  32  byte address; only bits `[$clog2(WindowBytes)-1:0]` are decoded
- `we_i`  in  1  write enable
- `be_i`  in  4  byte enables
- `wdata_i`  in  32  write data
- `aid_i`  in  IdWidth  request ID
- `rvalid_o`  out  1  response valid
- `rdata_o`  out  32  read data
- `err_o`  out  1  response error
- `rid_o`  out  IdWidth  response ID (echo of `aid_i`)
- `boot_addr_o`  out  32  current BOOTADDR
- `fetch_en_o`  out  1  FETCHEN bit 0
- `core_status_o`  out  32  current CORESTATUS
- `eoc_o`  out  1  one-cycle pulse on end of computation

## Operation
- Register map (word offsets):
  - 0x0 BOOTADDR: rw, 32 bits.
  - 0x4 FETCHEN: rw, bit 0 only; bits 31:1 read 0.
  - 0x8 CORESTATUS: rw, 32 bits.
  - 0xC: reserved, reads 0, writes ignored.
- `gnt_o` is tied to 1. Every request is accepted in the cycle `req_i` is high.
- Writes honour `be_i` per byte. `be_i == 4'h0` is a legal no-op write and still receives a response.
- Address bits [1:0] are ignored.
- End of computation: an accepted CORESTATUS write whose resulting bit 31 is 1, while the previous bit 31 was 0, pulses `eoc_o` in the following cycle.
  - Bits 30:0 of CORESTATUS carry the exit code.
  - Rewriting a value that already has bit 31 set does not re-pulse.
- Response state machine, two states:
  - IDLE -> RESP when a request is accepted.
  - RESP -> RESP when another request is accepted in the same cycle (back-to-back).
  - RESP -> IDLE otherwise.
  - `rvalid_o` is high in RESP.
- Read data is sampled at acceptance. Reads return register contents from before any write in that same cycle.
- Unmapped offset (at or above 0x10 within the window) without the configuration macro: reads return 0, writes are ignored, `err_o` = 0.

## Timing
- Reset values:
  - `boot_addr_o` = `BootAddrDefault`
  - `fetch_en_o` = 0, `core_status_o` = 0, `eoc_o` = 0
  - `rvalid_o` = 0, `rdata_o` = 0, `err_o` = 0, `rid_o` = 0
- Latency: request accepted in cycle N produces `rvalid_o`, `rdata_o`, `err_o` and `rid_o` in cycle N+1, each held for exactly one cycle. Throughput is one transaction per cycle.
- Register outputs (`boot_addr_o`, `fetch_en_o`, `core_status_o`) update in cycle N+1, together with the write response.
- `eoc_o` goes high in cycle N+1 and low in N+2.
- Reset asserted mid-transaction: the pending response is dropped. `rvalid_o` and `eoc_o` drop asynchronously and all registers return to their reset values.
- No backpressure exists on the response channel. The requester must accept `rvalid_o` unconditionally (OBI without `rready`).

## Configuration
- `SOC_CTRL_ERR_RESP_EN`
  - Defined: accesses to unmapped offsets (0xC and at or above 0x10) respond with `err_o` = 1 and `rdata_o` = 0, and writes are ignored. Writes to FETCHEN with any of bits 31:1 set under an enabled byte also respond with `err_o` = 1; bit 0 is still written.
  - Not defined: `err_o` is constant 0 and all such accesses complete silently as described under Operation.

## Test plan
- Reset, then read 0x0, 0x4, 0x8 back-to-back -> three consecutive `rvalid_o` cycles returning 0x1000_0000, 0, 0 with `rid_o` echoing IDs 1, 0, 1.
- Write 0x0 = 0xDEAD_BEEF with `be_i` = 4'b0101 -> `boot_addr_o` = 0x10AD_00EF one cycle after acceptance; read-back matches.
- Write 0x4 = 1 -> `fetch_en_o` rises in cycle N+1. Then write 0x4 = 0xFFFF_FFFE -> `fetch_en_o` = 0 and read-back = 0.
- Write 0x8 = 0x8000_0000 -> `eoc_o` is a single-cycle pulse at N+1 and `core_status_o` = 0x8000_0000. Rewrite the same value -> no pulse. Write 0, then 0x8000_0005 -> second pulse, exit code 5.
- Read then write 0x8 in consecutive cycles (write 0x1234) -> read returns the old value, and a subsequent read returns 0x1234.
- Access offset 0x40 -> `err_o` = 1 with `SOC_CTRL_ERR_RESP_EN` defined, 0 without; `rdata_o` = 0 in both cases. Assert `rst_ni` low during a pending response -> `rvalid_o` = 0 immediately.
